// File: rtl/mdu_unit_pkg.sv
// rtl/mdu_unit_pkg.sv - MDU op codes, default latencies and operand helpers
package mdu_unit_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic [31:0] mdu_abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic [63:0] mdu_sext64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// rtl/mdu_unit_if.sv - EX-stage request / HI-LO result bundle of the multiply/divide unit
interface mdu_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle MULT/DIV unit owning HI/LO; MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        clr,
    mdu_unit_if.slave   bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0] prod_u, prod_s;
    logic        div_signed;
    logic [31:0] div_a, div_b, quot_u, rem_u, quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        res_we;

    assign bus.busy = (cnt_q != '0);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        prod_u     = {32'd0, rs_q} * {32'd0, rt_q};
        prod_s     = mdu_sext64(rs_q) * mdu_sext64(rt_q);
        div_signed = (op_q == MDU_DIV);
        div_a      = div_signed ? mdu_abs32(rs_q) : rs_q;
        div_b      = div_signed ? mdu_abs32(rt_q) : rt_q;
        quot_u     = (div_b != 32'd0) ? (div_a / div_b) : 32'd0;
        rem_u      = (div_b != 32'd0) ? (div_a % div_b) : 32'd0;
        quot       = (div_signed && (rs_q[31] ^ rt_q[31])) ? (32'd0 - quot_u) : quot_u;
        rem        = (div_signed && rs_q[31]) ? (32'd0 - rem_u) : rem_u;
    end

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            MDU_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_we           = 1'b1;
            end
            MDU_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_we           = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                res_hi = rem;
                res_lo = quot;
                res_we = (rt_q != 32'd0);
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
                res_we           = 1'b1;
            end
            MDU_MADDU: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
                res_we           = 1'b1;
            end
            MDU_MSUB: begin
                {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
                res_we           = 1'b1;
            end
            MDU_MSUBU: begin
                {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
                res_we           = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // A busy unit ignores start entirely, MTHI/MTLO included.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        rs_d  = rs_q;
        rt_d  = rt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && res_we) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end else if (bus.start) begin
            case (bus.op)
                MDU_MULT, MDU_MULTU
`ifdef MDU_MADD_EN
                , MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU
`endif
                : begin
                    op_d  = bus.op;
                    rs_d  = bus.rs_data;
                    rt_d  = bus.rt_data;
                    cnt_d = CNT_W'(MULT_LAT);
                end
                MDU_DIV, MDU_DIVU: begin
                    op_d  = bus.op;
                    rs_d  = bus.rs_data;
                    rt_d  = bus.rt_data;
                    cnt_d = CNT_W'(DIV_LAT);
                end
                MDU_MTHI: hi_d = bus.rs_data;
                MDU_MTLO: lo_d = bus.rs_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
            op_q  <= 4'd0;
            rs_q  <= 32'd0;
            rt_q  <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            rs_q  <= rs_d;
            rt_q  <= rt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule
